// File: rtl/tinyqv_seq_pkg.sv
// tinyqv_seq_pkg
//   Shared definitions for the TinyQV instruction sequencer:
//   sequencer state encoding, nibble-per-pass count, instruction length
//   encodings and the pc advance helper.
package tinyqv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  // One 4-bit slice per cycle, so a 32-bit pass takes eight cycles.
  localparam int         NIBBLES     = 8;
  localparam logic [2:0] LAST_NIBBLE = 3'(NIBBLES - 1);

  // instr_len is in halfword units.
  localparam logic [2:1] LEN_16 = 2'd1;
  localparam logic [2:1] LEN_32 = 2'd2;

  // Sequential pc advance; wraps modulo 2^23.
  function automatic logic [23:1] pc_advance(input logic [23:1] pc_cur,
                                             input logic [2:1]  len);
    return pc_cur + {21'd0, len};
  endfunction

endpackage

// File: rtl/tinyqv_seq_timeout.sv
// tinyqv_seq_timeout
//   Memory-acknowledge wait counter with timeout compare.
//   Ports:
//     clk     - clock
//     rstn    - synchronous active-low reset
//     active  - sequencer is waiting for memory (counts while high)
//     ack     - memory acknowledge; restarts the count
//     expired - this is the last allowed wait cycle and no ack arrived
module tinyqv_seq_timeout #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int         W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (!active || ack) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The count reaches MEM_TIMEOUT at the end of this cycle; ack wins a tie.
  assign expired = active && !ack && (wait_cnt == LAST);

endmodule

// File: rtl/tinyqv_sequencer.sv
// tinyqv_sequencer
//   Nibble-serial execution sequencer for the TinyQV core. Steps the core
//   through 8-cycle passes, parks it while a load/store is outstanding,
//   retires instructions and tracks the pc.
//   Ports:
//     clk, rstn       - clock, synchronous active-low reset
//     instr_valid     - fetch buffer holds a decoded instruction
//     instr_len       - instruction length in halfwords (1 or 2)
//     is_mem          - current instruction is a load/store
//     address_ready   - core produced the memory address this pass
//     mem_ack         - memory transaction completed
//     instr_complete  - core finishes the instruction on this pass
//     branch          - control transfer taken at completion
//     branch_target   - destination pc for a taken branch
//     counter         - nibble index presented to the core
//     core_run        - core datapath advances this cycle
//     instr_accept    - one-cycle retire pulse
//     pc              - pc of the executing instruction
//     mem_req         - memory transaction outstanding
//     fault           - sticky memory-timeout flag
module tinyqv_sequencer
  import tinyqv_seq_pkg::*;
#(
  parameter logic [23:1] RESET_PC    = 23'h0,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         instr_valid,
  input  logic [2:1]   instr_len,
  input  logic         is_mem,
  input  logic         address_ready,
  input  logic         mem_ack,
  input  logic         instr_complete,
  input  logic         branch,
  input  logic [23:1]  branch_target,
  output logic [2:0]   counter,
  output logic         core_run,
  output logic         instr_accept,
  output logic [23:1]  pc,
  output logic         mem_req,
  output logic         fault
);

  seq_state_t state;
  logic       mem_done;
  logic       timeout_hit;
  logic       last_nibble;
  logic       go_mem_wait;
  logic       retire;

  tinyqv_seq_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .active (state == MEM_WAIT),
    .ack    (mem_ack),
    .expired(timeout_hit)
  );

  assign last_nibble = (state == EXEC) && (counter == LAST_NIBBLE);
  // Entering the memory wait takes priority over retiring on the same pass.
  assign go_mem_wait = last_nibble && is_mem && address_ready && !mem_done;
  assign retire      = last_nibble && instr_complete && !go_mem_wait;

  // Gated by rstn so a reset cycle never produces a retire pulse.
  assign instr_accept = rstn && retire;
  assign core_run     = (state == EXEC);
  assign mem_req      = (state == MEM_WAIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      counter  <= '0;
      pc       <= RESET_PC;
      mem_done <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (instr_valid) state <= EXEC;
        end
        EXEC: begin
          // Wraps 7 -> 0 for every outcome at the end of a pass.
          counter <= counter + 3'd1;
          if (go_mem_wait) begin
            state <= MEM_WAIT;
          end else if (retire) begin
            pc       <= branch ? branch_target : pc_advance(pc, instr_len);
            mem_done <= 1'b0;
            state    <= instr_valid ? EXEC : IDLE;
          end
        end
        MEM_WAIT: begin
          counter <= '0;
          if (mem_ack) begin
            mem_done <= 1'b1;
            state    <= EXEC;
          end else if (timeout_hit) begin
            fault <= 1'b1;
            state <= HALT;
          end
        end
        HALT: begin
          counter <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
